// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: FSM states, memory opcodes and phase values.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        ERR   = 3'd4
    } seq_state_t;

    localparam logic [3:0] OP_LW = 4'b1001;
    localparam logic [3:0] OP_SW = 4'b1010;

    localparam logic PH_FETCH = 1'b0;
    localparam logic PH_EXEC  = 1'b1;

    // Loads and stores need a second memory access after decode.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Counts consecutive memory wait cycles; expired flags the cycle whose wait reaches WAIT_TIMEOUT.
module wait_timer #(
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    logic [7:0] count_reg;
    logic [7:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = 8'd0;
        end else if (count && (count_reg != 8'hFF)) begin
            count_next = count_reg + 8'd1;
        end
    end

    // Looks at the post-increment value so the error is taken on the edge ending the Nth wait cycle.
    assign expired = count && (count_next == 8'(WAIT_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 8'd0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: arbitrates the single memory port and strobes IR load and instruction commit.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             mem_ready,
    output logic             state,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_load,
    output logic             exec_commit,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retired
);

    seq_state_t       state_reg;
    seq_state_t       state_next;
    logic             store_reg;
    logic             timeout_err_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             timer_active;
    logic             timer_expired;

    // The timer only runs while a request is outstanding and restarts after every completion.
    assign timer_active = (state_reg == FETCH) || (state_reg == MEM);

    wait_timer #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!timer_active || mem_ready),
        .count   (timer_active && !mem_ready),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                if (mem_ready)          state_next = EXEC;
                else if (timer_expired) state_next = ERR;
            end
            EXEC: begin
                if (is_mem_op(opcode)) state_next = MEM;
                else if (run)          state_next = FETCH;
                else                   state_next = IDLE;
            end
            MEM: begin
                if (mem_ready)          state_next = run ? FETCH : IDLE;
                else if (timer_expired) state_next = ERR;
            end
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        state       = PH_FETCH;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        halted      = 1'b0;
        ir_load     = 1'b0;
        exec_commit = 1'b0;
        case (state_reg)
            IDLE:  halted = 1'b1;
            FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
            end
            EXEC: begin
                state       = PH_EXEC;
                exec_commit = !is_mem_op(opcode);
            end
            MEM: begin
                state       = PH_EXEC;
                mem_req     = 1'b1;
                mem_we      = store_reg;
                exec_commit = mem_ready;
            end
            ERR:     halted = 1'b1;
            default: halted = 1'b1;
        endcase
    end

    // Store direction is latched at decode so mem_we is a pure function of registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_reg       <= 1'b0;
            timeout_err_reg <= 1'b0;
            retired_reg     <= '0;
        end else begin
            if (state_reg == EXEC) begin
                store_reg <= (opcode == OP_SW);
            end
            if (state_next == ERR) begin
                timeout_err_reg <= 1'b1;
            end
            if (exec_commit) begin
                retired_reg <= retired_reg + 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
    assign retired     = retired_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: builds each instruction's expected cycle schedule and compares every cycle.
module tb_cpu_sequencer;

    localparam int TB_TIMEOUT = 4;
    localparam int TB_CNT_W   = 4;
    localparam logic [3:0] T_LW  = 4'b1001;
    localparam logic [3:0] T_SW  = 4'b1010;
    localparam logic [3:0] T_ALU = 4'b0010;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                run = 1'b0;
    logic [3:0]          opcode = 4'd0;
    logic                mem_ready = 1'b0;
    logic                state;
    logic                mem_req;
    logic                mem_we;
    logic                ir_load;
    logic                exec_commit;
    logic                halted;
    logic                timeout_err;
    logic [TB_CNT_W-1:0] retired;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_retired = 0;

    // {state, mem_req, mem_we, ir_load, exec_commit, halted, timeout_err}
    wire [6:0] outs = {state, mem_req, mem_we, ir_load, exec_commit, halted, timeout_err};
    localparam logic [6:0] OUT_IDLE = 7'b000_0010;
    localparam logic [6:0] OUT_ERR  = 7'b000_0011;

    cpu_sequencer #(
        .WAIT_TIMEOUT(TB_TIMEOUT),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .state       (state),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .ir_load     (ir_load),
        .exec_commit (exec_commit),
        .halted      (halted),
        .timeout_err (timeout_err),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        mem_ready = 1'b0;
        opcode = 4'd0;
        exp_retired = 0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        n_checks++;
        if (outs !== OUT_IDLE || retired !== '0) begin
            n_fail++;
            $display("FAIL reset: outs=%b retired=%0d expected outs=%b retired=0", outs, retired, OUT_IDLE);
        end
        next_cycle();
    endtask

    task automatic start_run();
        run = 1'b1;
        mem_ready = 1'($urandom);
        #1;
        n_checks++;
        if (outs !== OUT_IDLE) begin
            n_fail++;
            $display("FAIL idle_start: outs=%b expected %b", outs, OUT_IDLE);
        end
        next_cycle();
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom);
            #1;
            n_checks++;
            if (outs !== OUT_IDLE) begin
                n_fail++;
                $display("FAIL %s idle[%0d]: outs=%b expected %b", tag, i, outs, OUT_IDLE);
            end
            next_cycle();
        end
    endtask

    // Entered in the first FETCH cycle; drives one full instruction and checks every cycle of it.
    task automatic run_instr(input logic [3:0] op, input int wf, input int wm, input bit keep_run, input string tag);
        bit memop;
        bit store;
        logic [6:0] exp;
        memop = (op == T_LW) || (op == T_SW);
        store = (op == T_SW);
        run = 1'b1;
        for (int i = 0; i <= wf; i++) begin
            opcode = 4'($urandom);
            mem_ready = (i == wf);
            #1;
            exp = {1'b0, 1'b1, 1'b0, 1'(i == wf), 1'b0, 1'b0, 1'b0};
            n_checks++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL %s fetch[%0d]: outs=%b expected %b", tag, i, outs, exp);
            end
            next_cycle();
        end
        opcode = op;
        mem_ready = 1'($urandom);
        run = memop ? 1'b1 : keep_run;
        #1;
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'(!memop), 1'b0, 1'b0};
        n_checks++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL %s exec op=%b: outs=%b expected %b", tag, op, outs, exp);
        end
        next_cycle();
        if (memop) begin
            run = keep_run;
            for (int i = 0; i <= wm; i++) begin
                mem_ready = (i == wm);
                #1;
                exp = {1'b1, 1'b1, store, 1'b0, 1'(i == wm), 1'b0, 1'b0};
                n_checks++;
                if (outs !== exp) begin
                    n_fail++;
                    $display("FAIL %s mem[%0d] op=%b: outs=%b expected %b", tag, i, op, outs, exp);
                end
                next_cycle();
            end
        end
        exp_retired++;
        n_checks++;
        if (retired !== TB_CNT_W'(exp_retired)) begin
            n_fail++;
            $display("FAIL %s retired: got %0d expected %0d", tag, retired, TB_CNT_W'(exp_retired));
        end
    endtask

    task automatic test_reset();
        do_reset();
        idle_cycles(2, "reset_hold");
    endtask

    task automatic test_alu_seq();
        do_reset();
        start_run();
        for (int i = 0; i < 4; i++) run_instr(T_ALU, 0, 0, i < 3, "alu4");
        n_checks++;
        if (retired !== 4'd4) begin
            n_fail++;
            $display("FAIL alu4_total: retired=%0d expected 4", retired);
        end
        idle_cycles(2, "alu4_end");
    endtask

    task automatic test_store_wait();
        start_run();
        run_instr(T_SW, 0, 3, 1'b0, "sw_wait3");
        idle_cycles(1, "sw_wait3_end");
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0:       op = T_LW;
                1:       op = T_SW;
                default: op = 4'($urandom);
            endcase
            if (i == 0) start_run();
            run_instr(op, $urandom_range(0, TB_TIMEOUT - 1), $urandom_range(0, TB_TIMEOUT - 1), i < 23, "random");
        end
        idle_cycles(2, "random_end");
    endtask

    task automatic test_run_drop();
        start_run();
        run_instr(T_LW, 1, 2, 1'b0, "lw_run_drop");
        idle_cycles(3, "lw_run_drop_idle");
    endtask

    task automatic test_wrap();
        do_reset();
        start_run();
        for (int i = 0; i < 17; i++) run_instr(T_ALU, 0, 0, i < 16, "wrap");
        n_checks++;
        if (retired !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_total: retired=%0d expected 1", retired);
        end
    endtask

    task automatic test_async_reset();
        start_run();
        run_instr(T_ALU, 0, 0, 1'b1, "pre_areset");
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || retired === '0) begin
            n_fail++;
            $display("FAIL areset_pre: mem_req=%b retired=%0d expected mem_req=1 retired!=0", mem_req, retired);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (outs !== OUT_IDLE || retired !== '0) begin
            n_fail++;
            $display("FAIL areset_async: outs=%b retired=%0d expected outs=%b retired=0", outs, retired, OUT_IDLE);
        end
        exp_retired = 0;
        run = 1'b0;
        next_cycle();
        rst = 1'b0;
        idle_cycles(1, "areset_after");
    endtask

    task automatic test_timeout();
        do_reset();
        start_run();
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            mem_ready = 1'b0;
            #1;
            n_checks++;
            if (outs !== 7'b010_0000) begin
                n_fail++;
                $display("FAIL timeout_wait[%0d]: outs=%b expected %b", i, outs, 7'b010_0000);
            end
            next_cycle();
        end
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'($urandom);
            #1;
            n_checks++;
            if (outs !== OUT_ERR) begin
                n_fail++;
                $display("FAIL timeout_err[%0d]: outs=%b expected %b", i, outs, OUT_ERR);
            end
            next_cycle();
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_alu_seq();
        test_store_wait();
        test_run_drop();
        test_random();
        test_wrap();
        test_async_reset();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
